// File: rtl/calc_pkg.sv
// Shared arithmetic package: constants and state encoding for the BCD result converter.
package calc_pkg;
   localparam int BCD_W      = 4;
   localparam int CONV_ITERS = 8;
   localparam int DIGITS     = 3;

   typedef enum logic [1:0] {IDLE, CONVERT, FINISH} conv_state_t;
endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_adjust
   import calc_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   output logic [BCD_W-1:0] adjusted
);
   assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bcd_result_converter.sv
// Sequential signed binary-to-BCD converter: 8 shift-and-add-3 cycles, DONE one cycle later,
// one conversion per 10 cycles; START is ignored while BUSY.
module bcd_result_converter
   import calc_pkg::*;
#(
   parameter bit SIGNED_IN = 1'b1
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             START,
   input  logic [7:0]       Value,
   output logic             Negative,
   output logic [BCD_W-1:0] Hundreds,
   output logic [BCD_W-1:0] Tens,
   output logic [BCD_W-1:0] Ones,
   output logic             BUSY,
   output logic             DONE
);
   localparam int SCR_W = DIGITS * BCD_W;
   localparam logic [2:0] LAST_ITER = 3'(CONV_ITERS - 1);

   conv_state_t      state, state_nxt;
   logic [7:0]       bin;
   logic [SCR_W-1:0] scratch;
   logic [SCR_W-1:0] adj;
   logic [2:0]       cnt;
   logic             sign;
   logic             neg_in;
   logic [7:0]       magnitude;
   logic [SCR_W+7:0] shifted;

   // 8'h80 negates to 8'h80, which read unsigned is the required magnitude 128.
   assign neg_in    = SIGNED_IN && Value[7];
   assign magnitude = neg_in ? (~Value + 8'd1) : Value;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_adjust u_adj (
         .digit    (scratch[g*BCD_W +: BCD_W]),
         .adjusted (adj[g*BCD_W +: BCD_W])
      );
   end

   assign shifted = {adj, bin} << 1;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (START) state_nxt = CONVERT;
         CONVERT: if (cnt == LAST_ITER) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         bin      <= '0;
         scratch  <= '0;
         cnt      <= '0;
         sign     <= 1'b0;
         Negative <= 1'b0;
         Hundreds <= '0;
         Tens     <= '0;
         Ones     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (START) begin
                  bin     <= magnitude;
                  sign    <= neg_in;
                  scratch <= '0;
                  cnt     <= '0;
               end
            end
            CONVERT: begin
               {scratch, bin} <= shifted;
               cnt            <= cnt + 3'd1;
               // Publish on the final shift so the digits are already stable alongside DONE.
               if (cnt == LAST_ITER) begin
                  Negative <= sign;
                  Hundreds <= shifted[SCR_W+7 -: BCD_W];
                  Tens     <= shifted[SCR_W+7-BCD_W -: BCD_W];
                  Ones     <= shifted[SCR_W+7-2*BCD_W -: BCD_W];
               end
            end
            default: ;
         endcase
      end
   end

   assign BUSY = (state != IDLE);
   assign DONE = (state == FINISH);
endmodule

// File: tb/tb_bcd_result_converter.sv
// Directed bench for bcd_result_converter: signed default instance plus an unsigned instance.
module tb_bcd_result_converter;
   logic       CLOCK = 1'b0;
   logic       RESET;
   logic       START;
   logic [7:0] Value;
   logic       Negative, BUSY, DONE;
   logic [3:0] Hundreds, Tens, Ones;
   logic       u_neg, u_busy, u_done;
   logic [3:0] u_h, u_t, u_o;

   int checks = 0;
   int errors = 0;

   bcd_result_converter dut (
      .CLOCK(CLOCK), .RESET(RESET), .START(START), .Value(Value),
      .Negative(Negative), .Hundreds(Hundreds), .Tens(Tens), .Ones(Ones),
      .BUSY(BUSY), .DONE(DONE)
   );

   bcd_result_converter #(.SIGNED_IN(1'b0)) dut_u (
      .CLOCK(CLOCK), .RESET(RESET), .START(START), .Value(Value),
      .Negative(u_neg), .Hundreds(u_h), .Tens(u_t), .Ones(u_o),
      .BUSY(u_busy), .DONE(u_done)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic neg, input logic [3:0] h,
                            input logic [3:0] t, input logic [3:0] o);
      check({tag, "_neg"}, 16'(Negative), 16'(neg));
      check({tag, "_h"},   16'(Hundreds), 16'(h));
      check({tag, "_t"},   16'(Tens),     16'(t));
      check({tag, "_o"},   16'(Ones),     16'(o));
   endtask

   task automatic start_conv(input logic [7:0] v);
      Value = v;
      START = 1'b1;
      step();
      START = 1'b0;
   endtask

   // Counts edges from just after acceptance until DONE is seen, bounded at 20.
   task automatic wait_done(output int edges);
      edges = 0;
      while (DONE !== 1'b1 && edges < 20) begin
         step();
         edges++;
      end
   endtask

   initial begin
      int edges;
      int busy_cnt;
      int done_cnt;

      RESET = 1'b1;
      START = 1'b0;
      Value = 8'h00;
      step();
      step();
      check_out("rst", 1'b0, 4'd0, 4'd0, 4'd0);
      check("rst_busy", 16'(BUSY), 16'd0);
      check("rst_done", 16'(DONE), 16'd0);
      check("rst_u_busy", 16'(u_busy), 16'd0);
      RESET = 1'b0;
      step();

      // 127: latency exactly 8 cycles from acceptance to DONE.
      start_conv(8'd127);
      check("p127_busy", 16'(BUSY), 16'd1);
      wait_done(edges);
      check("p127_latency", 16'(edges), 16'd8);
      check("p127_busy_fin", 16'(BUSY), 16'd1);
      check_out("p127", 1'b0, 4'd1, 4'd2, 4'd7);
      step();
      check("p127_done_clr", 16'(DONE), 16'd0);
      check("p127_idle", 16'(BUSY), 16'd0);

      start_conv(8'h80);
      wait_done(edges);
      check("m128_latency", 16'(edges), 16'd8);
      check_out("m128", 1'b1, 4'd1, 4'd2, 4'd8);
      step();

      // Both instances convert 0xFF: -1 signed, 255 unsigned.
      start_conv(8'hFF);
      wait_done(edges);
      check("m1_latency", 16'(edges), 16'd8);
      check_out("m1", 1'b1, 4'd0, 4'd0, 4'd1);
      check("u255_done", 16'(u_done), 16'd1);
      check("u255_neg", 16'(u_neg), 16'd0);
      check("u255_digits", {4'd0, u_h, u_t, u_o}, 16'h0255);
      step();

      // Zero: BUSY high for 9 cycles, DONE exactly one cycle.
      start_conv(8'h00);
      busy_cnt = 0;
      done_cnt = 0;
      while (BUSY === 1'b1 && busy_cnt < 20) begin
         busy_cnt++;
         if (DONE === 1'b1) done_cnt++;
         step();
      end
      check("zero_busy_cycles", 16'(busy_cnt), 16'd9);
      check("zero_done_cycles", 16'(done_cnt), 16'd1);
      check_out("zero", 1'b0, 4'd0, 4'd0, 4'd0);

      // START re-pulsed with new Value 3 cycles into converting 42 must be ignored.
      start_conv(8'd42);
      step();
      step();
      start_conv(8'h11);
      check_out("p42_hold", 1'b0, 4'd0, 4'd0, 4'd0);
      done_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (DONE === 1'b1) done_cnt++;
         step();
      end
      check("p42_done_count", 16'(done_cnt), 16'd1);
      check_out("p42", 1'b0, 4'd0, 4'd4, 4'd2);

      // Reset mid-conversion after a 99 result; release with START already high.
      start_conv(8'd99);
      wait_done(edges);
      check("p99_latency", 16'(edges), 16'd8);
      check_out("p99", 1'b0, 4'd0, 4'd9, 4'd9);
      step();
      start_conv(8'd55);
      step();
      step();
      step();
      RESET = 1'b1;
      #1;
      check_out("abort", 1'b0, 4'd0, 4'd0, 4'd0);
      check("abort_busy", 16'(BUSY), 16'd0);
      check("abort_done", 16'(DONE), 16'd0);
      Value = 8'hF6;
      START = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (DONE === 1'b1) done_cnt++;
      end
      check("abort_no_done", 16'(done_cnt), 16'd0);
      RESET = 1'b0;
      step();
      START = 1'b0;
      check("rel_accept", 16'(BUSY), 16'd1);
      wait_done(edges);
      check("m10_latency", 16'(edges), 16'd8);
      check_out("m10", 1'b1, 4'd0, 4'd1, 4'd0);
      check("u246_digits", {3'd0, u_neg, u_h, u_t, u_o}, 16'h0246);
      step();
      check("m10_idle", 16'(BUSY), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
